slow_clock_monitor: RTL and testbench
=====================================

SLOW_CLOCK_MONITOR -- requirements
Module: slow_clock_monitor

Interface
REQ-001 Parameter CNT_W, default 32: width of the period and high-time counters.
REQ-002 Parameter TIMEOUT, default 100000000: ClkIn cycles without a SlowClk rising edge before a stall is declared; elaboration SHALL fail unless 2 <= TIMEOUT < 2**CNT_W.
REQ-003 ClkIn  input  1  the single clock; all logic is on its rising edge.
REQ-004 ResetN  input  1  asynchronous, active-low reset.
REQ-005 SlowClk  input  1  divided clock under observation, asynchronous to ClkIn.
REQ-006 Rise  output  1  one-cycle pulse per synchronized SlowClk rising edge.
REQ-007 Fall  output  1  one-cycle pulse per synchronized SlowClk falling edge.
REQ-008 Period  output  CNT_W  last measured SlowClk period, in ClkIn cycles.
REQ-009 PeriodValid  output  1  one-cycle pulse when Period is updated.
REQ-010 Stalled  output  1  level; high while SlowClk is considered stopped.
REQ-011 HighTime  output  CNT_W  last measured high time (present only with CLK_MON_HIGH_TIME_EN).

Function
REQ-012 SlowClk SHALL pass through a 2-flop synchronizer, then an edge register; Rise/Fall SHALL be registered and assert exactly 3 ClkIn edges after the first edge that samples the new SlowClk level.
REQ-013 The FSM SHALL have states WAIT_EDGE, MEASURE and STALL.
REQ-014 WAIT_EDGE: on Rise, clear the period counter and go to MEASURE; PeriodValid SHALL NOT assert.
REQ-015 MEASURE: the period counter SHALL increment every cycle; on Rise, Period SHALL load counter+1 (Period equals SlowClk period in ClkIn cycles), PeriodValid pulses in the same cycle Period changes, and the counter restarts.
REQ-016 Any state: a cycle counter since the last Rise (or since reset) reaching TIMEOUT SHALL move to STALL and set Stalled in that cycle.
REQ-017 STALL: Stalled held high; on Rise, Stalled clears the next cycle and the FSM enters MEASURE with no PeriodValid for that edge.
REQ-018 Period SHALL hold its last value through STALL and WAIT_EDGE; the counter cannot overflow because TIMEOUT < 2**CNT_W.
REQ-019 Rise and the timeout in the same cycle: Rise SHALL win; no stall is declared.
REQ-020 SlowClk constant from reset SHALL produce no Rise/Fall and Stalled after TIMEOUT cycles.

Reset
REQ-021 ResetN low SHALL asynchronously force: FSM=WAIT_EDGE, synchronizer and edge flops=0, counters=0, Rise=Fall=PeriodValid=Stalled=0, Period=0, HighTime=0.
REQ-022 Release SHALL be synchronous to ClkIn; a reset mid-measurement discards the partial count, and the first post-reset Rise SHALL NOT produce PeriodValid.

Configuration
REQ-023 Macro CLK_MON_HIGH_TIME_EN defined: a high-time counter SHALL clear on Rise, count while the synchronized level is high, and load HighTime (= high cycles) on Fall; HighTime port SHALL exist.
REQ-024 Macro undefined: no high-time counter and no HighTime port; all other behaviour identical.

Structure
REQ-025 A shared package clk_mon_pkg SHALL hold the FSM state enum (WAIT_EDGE, MEASURE, STALL) and the SYNC_STAGES=2 constant.
REQ-026 Sub-module sync_edge_detect (synchronizer + edge register, outputs level, Rise, Fall) SHALL be instantiated once.

Verification (CNT_W=16, TIMEOUT=100)
REQ-027 SlowClk 4 high/4 low -> first Rise gives no PeriodValid; every later Rise gives PeriodValid with Period=8.
REQ-028 Period changes from 8 to 12 (6/6) -> first full 12-cycle period reports Period=12, with no intermediate value.
REQ-029 SlowClk stops low after a Rise -> Stalled=1 exactly 100 cycles after that Rise; restart -> Stalled=0 one cycle after the next Rise, PeriodValid only from the second Rise onward.
REQ-030 ResetN pulsed low mid-period -> all outputs 0 immediately; the first post-reset Rise gives no PeriodValid; the second gives the correct Period.
REQ-031 SlowClk held high from reset -> no Rise/Fall pulses; Stalled=1 after 100 cycles.
REQ-032 With CLK_MON_HIGH_TIME_EN, SlowClk 3 high/5 low -> HighTime=3 after each Fall and Period=8.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared FSM state type and synchronizer depth for the slow clock monitor
package clk_mon_pkg;
  typedef enum logic [1:0] {WAIT_EDGE, MEASURE, STALL} state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronizes an asynchronous level and emits registered edge pulses
// Ports: clk, rst_n (async active-low) | din (async input)
//        level (synchronized level, aligned with rise/fall), rise, fall (one-cycle pulses)
module sync_edge_detect
  import clk_mon_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int D = SYNC_STAGES + 2;
  logic [D-1:0] pipe;
  logic [D-1:0] vld;
  // vld tracks which pipe stages hold genuine post-reset samples, so the
  // reset value of the pipe is never mistaken for a real level change
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pipe <= '0;
      vld  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      pipe <= {pipe[D-2:0], din};
      vld  <= {vld[D-2:0], 1'b1};
      rise <= vld[D-1] & pipe[D-2] & ~pipe[D-1];
      fall <= vld[D-1] & ~pipe[D-2] & pipe[D-1];
    end
  assign level = pipe[D-1];
endmodule

// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor: measures period of an asynchronous slow clock and flags stalls
// Ports: ClkIn, ResetN (async active-low) | SlowClk (observed clock)
//        Rise, Fall, PeriodValid (one-cycle pulses), Period, Stalled (level)
//        HighTime (only when CLK_MON_HIGH_TIME_EN is defined)
// Optional feature macro: CLK_MON_HIGH_TIME_EN
module slow_clock_monitor
  import clk_mon_pkg::*;
#(
  parameter int     CNT_W   = 32,
  parameter longint TIMEOUT = 100000000
) (
  input  logic             ClkIn,
  input  logic             ResetN,
  input  logic             SlowClk,
  output logic             Rise,
  output logic             Fall,
  output logic [CNT_W-1:0] Period,
  output logic             PeriodValid,
  output logic             Stalled
`ifdef CLK_MON_HIGH_TIME_EN
  ,
  output logic [CNT_W-1:0] HighTime
`endif
);
  if (TIMEOUT < 2 || TIMEOUT >= (64'sd1 <<< CNT_W)) begin : g_bad_timeout
    $error("slow_clock_monitor: TIMEOUT must satisfy 2 <= TIMEOUT < 2**CNT_W");
  end
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, tcnt;
  logic timeout, load;
`ifdef CLK_MON_HIGH_TIME_EN
  logic level;
  logic [CNT_W-1:0] hcnt;
`endif
  sync_edge_detect u_sync (
    .clk  (ClkIn),
    .rst_n(ResetN),
    .din  (SlowClk),
`ifdef CLK_MON_HIGH_TIME_EN
    .level(level),
`else
    .level(),
`endif
    .rise (Rise),
    .fall (Fall)
  );
  // tcnt counts cycles since the last Rise (the Rise cycle counts as 1);
  // a Rise arriving with the timeout takes priority
  assign timeout = !Rise && tcnt == TO_LAST;
  always_ff @(posedge ClkIn or negedge ResetN)
    if (!ResetN) state <= WAIT_EDGE;
    else state <= state_nx;
  always_comb state_nx = Rise ? MEASURE : timeout ? STALL : state;
  always_comb begin
    load    = Rise && state == MEASURE;
    Stalled = state == STALL;
  end
  always_ff @(posedge ClkIn or negedge ResetN)
    if (!ResetN) begin
      cnt         <= '0;
      tcnt        <= '0;
      Period      <= '0;
      PeriodValid <= 1'b0;
    end else begin
      cnt         <= Rise ? '0 : state == MEASURE ? cnt + 1'b1 : cnt;
      tcnt        <= Rise ? CNT_W'(1) : (timeout || state == STALL) ? tcnt : tcnt + 1'b1;
      PeriodValid <= load;
      if (load) Period <= cnt + 1'b1;
    end
`ifdef CLK_MON_HIGH_TIME_EN
  // Rise cycle is itself a high cycle, so a clear-on-rise starts at 1
  always_ff @(posedge ClkIn or negedge ResetN)
    if (!ResetN) begin
      hcnt     <= '0;
      HighTime <= '0;
    end else begin
      hcnt <= Rise ? CNT_W'(1) : (level && hcnt != '1) ? hcnt + 1'b1 : hcnt;
      if (Fall) HighTime <= hcnt;
    end
`endif
endmodule

// File: tb/tb_slow_clock_monitor.sv
// tb_slow_clock_monitor: randomized self-checking bench against a cycle-history reference model
module tb_slow_clock_monitor;
  localparam int CNT_W = 16;
  localparam int TO = 100;
  logic ClkIn = 1'b0;
  logic ResetN = 1'b0;
  logic SlowClk = 1'b0;
  logic Rise, Fall, PeriodValid, Stalled;
  logic [CNT_W-1:0] Period;
`ifdef CLK_MON_HIGH_TIME_EN
  logic [CNT_W-1:0] HighTime;
`endif
  slow_clock_monitor #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .ClkIn      (ClkIn),
    .ResetN     (ResetN),
    .SlowClk    (SlowClk),
    .Rise       (Rise),
    .Fall       (Fall),
    .Period     (Period),
    .PeriodValid(PeriodValid),
`ifdef CLK_MON_HIGH_TIME_EN
    .HighTime   (HighTime),
`endif
    .Stalled    (Stalled)
  );
  always #5 ClkIn = ~ClkIn;
  int total = 0;
  int bad = 0;
  // lv[k] is the SlowClk level sampled by the k-th ClkIn edge after reset release
  bit lv[$];
  int n, lr, pr, period_e, ht_e;
  bit has_lr, has_pr;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, n, act, exp);
    end
  endtask
  // an edge first sampled at cycle k-3 is reported at cycle k; samples taken
  // before reset release do not exist, so no edge is seen against them
  function automatic bit edge_at(input int k, input bit up);
    return k >= 5 && lv[k-3] == up && lv[k-4] != up;
  endfunction
  task automatic model_reset;
    lv.delete();
    lv.push_back(1'b0);
    n = 0; lr = 0; pr = 0; period_e = 0; ht_e = 0;
    has_lr = 0; has_pr = 0;
  endtask
  task automatic check_cycle;
    bit r, f, pv;
    r  = edge_at(n, 1'b1);
    f  = edge_at(n, 1'b0);
    pv = edge_at(n - 1, 1'b1) && has_pr && (n - 1 - pr) < TO;
    if (pv) period_e = n - 1 - pr;
    if (edge_at(n - 1, 1'b0)) ht_e = n - 1 - (has_lr ? lr : 4);
    check("rise", 32'(Rise), 32'(r));
    check("fall", 32'(Fall), 32'(f));
    check("pvalid", 32'(PeriodValid), 32'(pv));
    check("period", 32'(Period), period_e);
    check("stalled", 32'(Stalled), 32'((n - lr) >= TO));
`ifdef CLK_MON_HIGH_TIME_EN
    check("hightime", 32'(HighTime), ht_e);
`endif
    if (r) begin
      pr = lr; has_pr = has_lr;
      lr = n; has_lr = 1'b1;
    end
  endtask
  task automatic step(input bit v);
    lv.push_back(v);
    SlowClk = v;
    @(posedge ClkIn);
    n++;
    @(negedge ClkIn);
    check_cycle();
  endtask
  task automatic hold(input bit v, input int c);
    repeat (c) step(v);
  endtask
  task automatic wave(input int hi, input int lo, input int k);
    repeat (k) begin
      hold(1'b1, hi);
      hold(1'b0, lo);
    end
  endtask
  task automatic do_reset(input bit v);
    @(negedge ClkIn);
    #2;
    ResetN = 1'b0;
    SlowClk = v;
    #1;
    check("rst_rise", 32'(Rise), 0);
    check("rst_fall", 32'(Fall), 0);
    check("rst_pvalid", 32'(PeriodValid), 0);
    check("rst_period", 32'(Period), 0);
    check("rst_stalled", 32'(Stalled), 0);
`ifdef CLK_MON_HIGH_TIME_EN
    check("rst_hightime", 32'(HighTime), 0);
`endif
    @(negedge ClkIn);
    @(negedge ClkIn);
    ResetN = 1'b1;
    model_reset();
  endtask
  initial begin
    model_reset();
    do_reset(1'b0);
    wave(4, 4, 6);
    check("p8", 32'(Period), 8);
    wave(6, 6, 4);
    check("p12", 32'(Period), 12);
    hold(1'b0, 120);
    check("stall_low", 32'(Stalled), 1);
    wave(4, 4, 4);
    check("restart_p8", 32'(Period), 8);
    check("restart_nostall", 32'(Stalled), 0);
    wave(50, 49, 3);
    check("gap99", 32'(Period), 99);
    check("gap99_nostall", 32'(Stalled), 0);
    wave(5, 5, 2);
    hold(1'b1, 3);
    do_reset(1'b1);
    wave(4, 4, 4);
    check("post_rst_p8", 32'(Period), 8);
    do_reset(1'b1);
    hold(1'b1, 120);
    check("held_high_stall", 32'(Stalled), 1);
    do_reset(1'b0);
    wave(3, 5, 4);
    check("p8_3h", 32'(Period), 8);
`ifdef CLK_MON_HIGH_TIME_EN
    check("ht3", 32'(HighTime), 3);
`endif
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) do_reset(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) hold(1'($urandom_range(0, 1)), $urandom_range(90, 130));
      wave($urandom_range(2, 70), $urandom_range(2, 70), $urandom_range(1, 3));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
